// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, control FSM state codes, datapath mux
// encodings and the packed control word driven onto the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WRITE = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_I_EXEC    = 4'd8;
  localparam logic [3:0] S_I_WB      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;

  function automatic logic [3:0] dispatch(input logic [5:0] op);
    logic [3:0] s;
    s = S_TRAP;
    unique case (1'b1)
      (op == OP_LW),
      (op == OP_SW):    s = S_MEM_ADDR;
      (op == OP_RTYPE): s = S_R_EXEC;
      (op == OP_ADDI):  s = S_I_EXEC;
      (op == OP_BEQ):   s = S_BRANCH;
      (op == OP_J):     s = S_JUMP;
      default:          s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State -> control word decode. Only FETCH and MEM_WRITE look at
// mem_ready, for the enables that fire on the acknowledge cycle.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (1'b1)
      (state_i == S_FETCH): begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_4;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      (state_i == S_DECODE): begin
        ctrl_o.alu_src_b = SRCB_IMM2;
      end
      (state_i == S_MEM_ADDR): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      (state_i == S_MEM_READ): begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.i_or_d  = 1'b1;
      end
      (state_i == S_MEM_WRITE): begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      (state_i == S_MEM_WB): begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == S_R_EXEC): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      (state_i == S_R_WB): begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == S_I_EXEC): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      (state_i == S_I_WB): begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == S_BRANCH): begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      (state_i == S_JUMP): begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == S_TRAP): begin
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/wb and
// owns the memory request handshake.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;

  // funct goes to ALU control and zero is gated in the datapath
  logic unused_in;
  assign unused_in = ^{funct, zero};

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (1'b1)
      (state_q == S_FETCH): begin
        if (mem_ready) state_d = S_DECODE;
      end
      (state_q == S_DECODE): begin
        state_d = dispatch(opcode);
        if (dispatch(opcode) == S_TRAP) illegal_d = 1'b1;
      end
      (state_q == S_MEM_ADDR): begin
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      (state_q == S_MEM_READ): begin
        if (mem_ready) state_d = S_MEM_WB;
      end
      (state_q == S_MEM_WRITE): begin
        if (mem_ready) state_d = S_FETCH;
      end
      (state_q == S_R_EXEC): state_d = S_R_WB;
      (state_q == S_I_EXEC): state_d = S_I_WB;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // Reset must silence the bus at once, even though FETCH requests memory
  assign ctrl = rst_n ? ctrl_raw : '0;

  assign mem_req       = ctrl.mem_req;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign instr_done    = ctrl.instr_done;
  assign illegal       = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed instructions plus random
// instruction streams checked cycle by cycle against a phase-level model.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic       pc_write_cond, alu_src_a, reg_write, reg_dst;
  logic       mem_to_reg, illegal, instr_done;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  int nvec = 0;
  int nerr = 0;
  bit exp_ill = 1'b0;

  typedef enum {
    P_FETCH, P_DECODE, P_MADDR, P_MREAD, P_MWRITE, P_MWB,
    P_REXEC, P_RWB, P_IEXEC, P_IWB, P_BRANCH, P_JUMP, P_TRAP
  } phase_e;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] code_of(input phase_e p);
    case (p)
      P_FETCH:  return S_FETCH;
      P_DECODE: return S_DECODE;
      P_MADDR:  return S_MEM_ADDR;
      P_MREAD:  return S_MEM_READ;
      P_MWRITE: return S_MEM_WRITE;
      P_MWB:    return S_MEM_WB;
      P_REXEC:  return S_R_EXEC;
      P_RWB:    return S_R_WB;
      P_IEXEC:  return S_I_EXEC;
      P_IWB:    return S_I_WB;
      P_BRANCH: return S_BRANCH;
      P_JUMP:   return S_JUMP;
      default:  return S_TRAP;
    endcase
  endfunction

  // Expected bus: {req,wr,iord,irw,pcw,pcwc,pcs,srca,srcb,aluop,
  //                regw,regdst,m2r,illegal,done,state}
  function automatic logic [21:0] model(input phase_e p, input bit rdy);
    bit req, wr, iord, irw, pcw, pcwc, srca, rw, rd, m2r, done;
    logic [1:0] pcs, srcb, aop;
    {req, wr, iord, irw, pcw, pcwc, srca, rw, rd, m2r, done} = '0;
    pcs = 2'd0; srcb = 2'd0; aop = 2'd0;
    case (p)
      P_FETCH:  begin req = 1; srcb = 2'd1; irw = rdy; pcw = rdy; end
      P_DECODE: srcb = 2'd3;
      P_MADDR:  begin srca = 1; srcb = 2'd2; end
      P_MREAD:  begin req = 1; iord = 1; end
      P_MWRITE: begin req = 1; wr = 1; iord = 1; done = rdy; end
      P_MWB:    begin rw = 1; m2r = 1; done = 1; end
      P_REXEC:  begin srca = 1; aop = 2'd2; end
      P_RWB:    begin rw = 1; rd = 1; done = 1; end
      P_IEXEC:  begin srca = 1; srcb = 2'd2; end
      P_IWB:    begin rw = 1; done = 1; end
      P_BRANCH: begin srca = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; done = 1; end
      P_JUMP:   begin pcw = 1; pcs = 2'd2; done = 1; end
      default:  done = 1;
    endcase
    return {req, wr, iord, irw, pcw, pcwc, pcs, srca, srcb, aop,
            rw, rd, m2r, exp_ill, done, code_of(p)};
  endfunction

  function automatic logic [21:0] observed();
    return {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
            pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
            mem_to_reg, illegal, instr_done, state};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One clock of the instruction: drive at negedge, check just after
  task automatic step(input phase_e p, input bit rdy,
                      input logic [5:0] op, input bit z);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    funct     = 6'($urandom);
    #1;
    chk(p.name(), 32'(observed()), 32'(model(p, rdy)));
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  task automatic run_instr(input logic [5:0] op, input bit z,
                           input int wf, input int wm);
    for (int i = 0; i < wf; i++) step(P_FETCH, 1'b0, 6'($urandom), 1'($urandom));
    step(P_FETCH, 1'b1, 6'($urandom), 1'($urandom));
    step(P_DECODE, 1'($urandom), op, 1'($urandom));
    if (op == OP_LW || op == OP_SW) begin
      step(P_MADDR, 1'($urandom), op, 1'($urandom));
      if (op == OP_LW) begin
        for (int i = 0; i < wm; i++) step(P_MREAD, 1'b0, 6'($urandom), 1'($urandom));
        step(P_MREAD, 1'b1, 6'($urandom), 1'($urandom));
        step(P_MWB, 1'($urandom), 6'($urandom), 1'($urandom));
      end else begin
        for (int i = 0; i < wm; i++) step(P_MWRITE, 1'b0, 6'($urandom), 1'($urandom));
        step(P_MWRITE, 1'b1, 6'($urandom), 1'($urandom));
      end
    end else if (op == OP_RTYPE) begin
      step(P_REXEC, 1'($urandom), 6'($urandom), 1'($urandom));
      step(P_RWB, 1'($urandom), 6'($urandom), 1'($urandom));
    end else if (op == OP_ADDI) begin
      step(P_IEXEC, 1'($urandom), 6'($urandom), 1'($urandom));
      step(P_IWB, 1'($urandom), 6'($urandom), 1'($urandom));
    end else if (op == OP_BEQ) begin
      step(P_BRANCH, 1'($urandom), 6'($urandom), z);
    end else if (op == OP_J) begin
      step(P_JUMP, 1'($urandom), 6'($urandom), 1'($urandom));
    end else begin
      exp_ill = 1'b1;
      step(P_TRAP, 1'($urandom), 6'($urandom), 1'($urandom));
    end
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    exp_ill = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(S_FETCH));
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_ctrl"}, 32'({ir_write, pc_write, reg_write, alu_op}), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  logic [5:0] legal_ops [6];
  logic [5:0] rop;

  initial begin
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    rst_n = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    reset_now("por");
    @(negedge clk);
    // Reset in the middle of a fetch that memory has not acknowledged
    step(P_FETCH, 1'b0, 6'd0, 1'b0);
    step(P_FETCH, 1'b0, 6'd0, 1'b0);
    reset_now("mid_fetch");
    // add r3,r1,r2 style R-type, zero wait
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    // lw with a two-cycle data wait
    run_instr(OP_LW, 1'b0, 0, 2);
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 1, 0);
    run_instr(OP_SW, 1'b0, 2, 1);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    // Trap must stick across later legal instructions
    run_instr(6'd63, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 1, 0);
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    reset_now("clr_illegal");
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do rop = 6'($urandom); while (is_legal(rop));
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(rop, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    // Reset while a data read is outstanding
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    step(P_FETCH, 1'b1, 6'd0, 1'b0);
    step(P_DECODE, 1'b0, OP_LW, 1'b0);
    step(P_MADDR, 1'b0, OP_LW, 1'b0);
    step(P_MREAD, 1'b0, 6'd0, 1'b0);
    reset_now("mid_read");
    run_instr(OP_SW, 1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
